mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the single shared memory_unit port. It replaces the select-driven memory_mux.
- Requesters are the MTU, execute, cell, incr and equal blocks. Each raises a request carrying its full memory command. The arbiter grants one requester at a time, issues the execute pulse, tracks is_ready through completion, and returns read data with a done pulse.
- Optional per-requester lock keeps ownership across back-to-back transactions, e.g. read-then-write sequences.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_rr_picker.sv | 30 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W      = 8;
  localparam int MEM_DATA_W      = 16;
  localparam int NUM_REQ_DEFAULT = 5;

  localparam int REQ_MTU     = 0;
  localparam int REQ_EXECUTE = 1;
  localparam int REQ_CELL    = 2;
  localparam int REQ_INCR    = 3;
  localparam int REQ_EQUAL   = 4;

  localparam logic [1:0] MEM_FUNC_READ  = 2'd0;
  localparam logic [1:0] MEM_FUNC_WRITE = 2'd1;
  localparam logic [1:0] MEM_FUNC_INCR  = 2'd2;
  localparam logic [1:0] MEM_FUNC_EQUAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin priority encoder
module rr_picker #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  // Scan starting at rr_ptr and wrapping; the first set request wins.
  always_comb begin
    int cand;
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_valid && req[cand]) begin
        pick_valid        = 1'b1;
        pick_onehot[cand] = 1'b1;
        pick_idx          = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter and sequencer for the shared memory_unit port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [2*NUM_REQ-1:0]      func_in,
  input  logic [ADDR_W*NUM_REQ-1:0] addr1_in,
  input  logic [ADDR_W*NUM_REQ-1:0] addr2_in,
  input  logic [DATA_W*NUM_REQ-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata1,
  output logic [DATA_W-1:0]         rdata2,
  output logic [1:0]                mem_func,
  output logic                      mem_execute,
  output logic [ADDR_W-1:0]         mem_address1,
  output logic [ADDR_W-1:0]         mem_address2,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_read_data1,
  input  logic [DATA_W-1:0]         mem_read_data2,
  output logic                      busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant_q;
  logic [1:0]         func_q;
  logic [ADDR_W-1:0]  addr1_q;
  logic [ADDR_W-1:0]  addr2_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata1_q;
  logic [DATA_W-1:0]  rdata2_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               start;
  logic               relock;
  logic [IDX_W-1:0]   ptr_after_owner;

  logic [IDX_W-1:0]   cmd_sel;
  logic [1:0]         sel_func;
  logic [ADDR_W-1:0]  sel_addr1;
  logic [ADDR_W-1:0]  sel_addr2;
  logic [DATA_W-1:0]  sel_wdata;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  assign start           = mem_ready && pick_valid;
  assign relock          = lock[owner] && req[owner];
  assign ptr_after_owner = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // A locked re-issue reloads from the current owner; otherwise from the new pick.
  always_comb begin
    cmd_sel   = (state == ST_RESP) ? owner : pick_idx;
    sel_func  = func_in[int'(cmd_sel)*2 +: 2];
    sel_addr1 = addr1_in[int'(cmd_sel)*ADDR_W +: ADDR_W];
    sel_addr2 = addr2_in[int'(cmd_sel)*ADDR_W +: ADDR_W];
    sel_wdata = wdata_in[int'(cmd_sel)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!mem_ready) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (mem_ready) state_nxt = ST_RESP;
      ST_RESP:      state_nxt = relock ? ST_ISSUE : ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_execute = (state == ST_ISSUE);
    busy        = (state != ST_IDLE);
    done        = (state == ST_RESP) ? grant_q : '0;
  end

  // Command fields are frozen between grant/re-issue so requester edits are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      grant_q  <= '0;
      func_q   <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            grant_q <= pick_onehot;
            owner   <= pick_idx;
            func_q  <= sel_func;
            addr1_q <= sel_addr1;
            addr2_q <= sel_addr2;
            wdata_q <= sel_wdata;
          end
        end
        ST_WAIT_DONE: begin
          if (mem_ready) begin
            rdata1_q <= mem_read_data1;
            rdata2_q <= mem_read_data2;
          end
        end
        ST_RESP: begin
          if (relock) begin
            func_q  <= sel_func;
            addr1_q <= sel_addr1;
            addr2_q <= sel_addr2;
            wdata_q <= sel_wdata;
          end else begin
            grant_q <= '0;
            rr_ptr  <= ptr_after_owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant          = grant_q;
  assign rdata1         = rdata1_q;
  assign rdata2         = rdata2_q;
  assign mem_func       = func_q;
  assign mem_address1   = addr1_q;
  assign mem_address2   = addr2_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N   = 5;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 3;

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [2*N-1:0]  func_in;
  logic [AW*N-1:0] addr1_in;
  logic [AW*N-1:0] addr2_in;
  logic [DW*N-1:0] wdata_in;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata1;
  logic [DW-1:0]   rdata2;
  logic [1:0]      mem_func;
  logic            mem_execute;
  logic [AW-1:0]   mem_address1;
  logic [AW-1:0]   mem_address2;
  logic [DW-1:0]   mem_write_data;
  logic            mem_ready;
  logic [DW-1:0]   mem_read_data1;
  logic [DW-1:0]   mem_read_data2;
  logic            busy;

  logic [1:0]    f  [N];
  logic [AW-1:0] a1 [N];
  logic [AW-1:0] a2 [N];
  logic [DW-1:0] wd [N];
  int            rem [N];
  logic [N-1:0]  auto_inc;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_exec = 0;
  int   n_done = 0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .lock           (lock),
    .func_in        (func_in),
    .addr1_in       (addr1_in),
    .addr2_in       (addr2_in),
    .wdata_in       (wdata_in),
    .grant          (grant),
    .done           (done),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .mem_func       (mem_func),
    .mem_execute    (mem_execute),
    .mem_address1   (mem_address1),
    .mem_address2   (mem_address2),
    .mem_write_data (mem_write_data),
    .mem_ready      (mem_ready),
    .mem_read_data1 (mem_read_data1),
    .mem_read_data2 (mem_read_data2),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    func_in  = '0;
    addr1_in = '0;
    addr2_in = '0;
    wdata_in = '0;
    for (int i = 0; i < N; i++) begin
      func_in[2*i +: 2]    = f[i];
      addr1_in[AW*i +: AW] = a1[i];
      addr2_in[AW*i +: AW] = a2[i];
      wdata_in[DW*i +: DW] = wd[i];
    end
  end

  // Memory model: ram[i] resets to A000+i; a write returns the written data on read_data1.
  logic [DW-1:0] ram [256];
  logic          mem_ready_int;
  logic          mem_hold = 1'b0;
  int            mem_cnt;
  logic [1:0]    m_f;
  logic [AW-1:0] m_a1, m_a2;
  logic [DW-1:0] m_wd;

  assign mem_ready = mem_ready_int && !mem_hold;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= DW'(16'hA000 + i);
      mem_ready_int  <= 1'b1;
      mem_cnt        <= 0;
      mem_read_data1 <= '0;
      mem_read_data2 <= '0;
    end else if (mem_ready && mem_execute) begin
      mem_ready_int <= 1'b0;
      mem_cnt       <= LAT;
      m_f           <= mem_func;
      m_a1          <= mem_address1;
      m_a2          <= mem_address2;
      m_wd          <= mem_write_data;
    end else if (!mem_ready_int) begin
      if (mem_cnt == 0) begin
        mem_ready_int <= 1'b1;
        if (m_f == MEM_FUNC_WRITE) begin
          ram[m_a1]      <= m_wd;
          mem_read_data1 <= m_wd;
        end else begin
          mem_read_data1 <= ram[m_a1];
        end
        mem_read_data2 <= ram[m_a2];
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [1:0] fn, input logic [AW-1:0] x1,
                         input logic [AW-1:0] x2, input logic [DW-1:0] w);
    f[i]   = fn;
    a1[i]  = x1;
    a2[i]  = x2;
    wd[i]  = w;
    rem[i] = 1;
  endtask

  task automatic push(input logic [N-1:0] d, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    exp_t e;
    e.done = d;
    e.rd1  = r1;
    e.rd2  = r2;
    sb.push_back(e);
  endtask

  // One cycle: sample at negedge, score any done, and let requesters react to it.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (mem_execute) n_exec++;
    check("grant_onehot0", 32'($onehot0(grant)), 1);
    if (|done) begin
      n_done++;
      check("done_within_grant", 32'((done & ~grant) == '0), 1);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        e = sb.pop_front();
        check("done_owner", 32'(done), 32'(e.done));
        check("rdata1", 32'(rdata1), 32'(e.rd1));
        check("rdata2", 32'(rdata2), 32'(e.rd2));
      end
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if (rem[i] > 0) rem[i]--;
          if (rem[i] == 0) begin
            req[i] = 1'b0;
          end else if (auto_inc[i]) begin
            a1[i] = a1[i] + 1'b1;
            wd[i] = wd[i] + 16'h1111;
          end
        end
      end
    end
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((sb.size() != 0 || busy) && k < max);
    check("drain_complete", 32'(sb.size() != 0 || busy), 0);
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    req      = '0;
    lock     = '0;
    auto_inc = '0;
    for (int i = 0; i < N; i++) begin
      f[i] = '0; a1[i] = '0; a2[i] = '0; wd[i] = '0; rem[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_exec", 32'(mem_execute), 0);
    check("rst_rdata1", 32'(rdata1), 0);
    check("rst_mem_addr1", 32'(mem_address1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read by requester 0.
    set_cmd(0, MEM_FUNC_READ, 8'd1, 8'd2, '0);
    push(5'b00001, 16'hA001, 16'hA002);
    req[0] = 1'b1;
    step();
    check("single_grant", 32'(grant), 32'(5'b00001));
    check("single_exec", 32'(mem_execute), 1);
    check("single_addr1", 32'(mem_address1), 1);
    step();
    check("single_exec_one_cycle", 32'(mem_execute), 0);
    drain(100);

    // Contention 1,2,4 from rr_ptr=1.
    set_cmd(1, MEM_FUNC_READ, 8'd3, 8'd0, '0);
    set_cmd(2, MEM_FUNC_READ, 8'd4, 8'd0, '0);
    set_cmd(4, MEM_FUNC_READ, 8'd5, 8'd0, '0);
    push(5'b00010, 16'hA003, 16'hA000);
    push(5'b00100, 16'hA004, 16'hA000);
    push(5'b10000, 16'hA005, 16'hA000);
    req = 5'b10110;
    step();
    check("contend_first_grant", 32'(grant), 32'(5'b00010));
    drain(300);

    // Wrap-around: serve 3, then 4 before 0, then pointer sits at 1.
    set_cmd(3, MEM_FUNC_READ, 8'd3, 8'd0, '0);
    push(5'b01000, 16'hA003, 16'hA000);
    req[3] = 1'b1;
    drain(100);
    set_cmd(4, MEM_FUNC_READ, 8'd4, 8'd0, '0);
    set_cmd(0, MEM_FUNC_READ, 8'd6, 8'd0, '0);
    push(5'b10000, 16'hA004, 16'hA000);
    push(5'b00001, 16'hA006, 16'hA000);
    req = 5'b10001;
    step();
    check("wrap_first_grant", 32'(grant), 32'(5'b10000));
    drain(200);
    set_cmd(1, MEM_FUNC_READ, 8'd11, 8'd0, '0);
    set_cmd(0, MEM_FUNC_READ, 8'd12, 8'd0, '0);
    push(5'b00010, 16'hA00B, 16'hA000);
    push(5'b00001, 16'hA00C, 16'hA000);
    req = 5'b00011;
    step();
    check("ptr_back_to_1", 32'(grant), 32'(5'b00010));
    drain(200);

    // Locked write burst by 2 while 1 waits; lock stays high with req low at the end.
    set_cmd(2, MEM_FUNC_WRITE, 8'd8, 8'd0, 16'h1111);
    rem[2]      = 3;
    auto_inc[2] = 1'b1;
    lock[2]     = 1'b1;
    push(5'b00100, 16'h1111, 16'hA000);
    push(5'b00100, 16'h2222, 16'hA000);
    push(5'b00100, 16'h3333, 16'hA000);
    req[2] = 1'b1;
    step();
    check("lock_grant", 32'(grant), 32'(5'b00100));
    set_cmd(1, MEM_FUNC_READ, 8'd9, 8'd10, '0);
    push(5'b00010, 16'h2222, 16'h3333);
    req[1] = 1'b1;
    drain(400);
    lock     = '0;
    auto_inc = '0;

    // Memory not ready blocks the grant.
    mem_hold = 1'b1;
    set_cmd(0, MEM_FUNC_READ, 8'd7, 8'd0, '0);
    push(5'b00001, 16'hA007, 16'hA000);
    req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("notready_no_grant", 32'(grant), 0);
      check("notready_no_exec", 32'(mem_execute), 0);
    end
    mem_hold = 1'b0;
    step();
    check("ready_grant", 32'(grant), 32'(5'b00001));
    drain(100);

    // Reset while waiting for memory completion.
    set_cmd(0, MEM_FUNC_READ, 8'd2, 8'd0, '0);
    req[0] = 1'b1;
    k = 0;
    while (!mem_execute && k < 20) begin
      step();
      k++;
    end
    check("rst_test_exec_seen", 32'(mem_execute), 1);
    step();
    step();
    check("rst_test_busy_before", 32'(busy), 1);
    rst    = 1'b1;
    req    = '0;
    rem[0] = 0;
    step();
    check("midrst_grant", 32'(grant), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_exec", 32'(mem_execute), 0);
    check("midrst_rdata1", 32'(rdata1), 0);
    check("midrst_rdata2", 32'(rdata2), 0);
    check("midrst_mem_addr1", 32'(mem_address1), 0);
    rst = 1'b0;
    repeat (6) step();
    set_cmd(0, MEM_FUNC_READ, 8'd5, 8'd6, '0);
    push(5'b00001, 16'hA005, 16'hA006);
    req[0] = 1'b1;
    drain(100);

    check("exec_count_vs_done", 32'(n_exec), 32'(n_done + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
